// File: rtl/ras_ckpt.sv
// Return address stack with push/pop, replace-top, saturating occupancy and
// checkpoint restore. The storage is circular, so any depth >= 2 is supported.
module ras_ckpt #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_INDEX_WIDTH:0]    restore_count,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_target,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int IW    = RAS_INDEX_WIDTH;
  localparam int CNT_W = RAS_INDEX_WIDTH + 1;
  localparam logic [IW-1:0]    MAX_IDX = IW'(RAS_ENTRIES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
  logic [IW-1:0]               ptr;
  logic [CNT_W-1:0]            count;
  logic [IW-1:0]               ptr_inc;
  logic [IW-1:0]               ptr_dec;

  // Wrap compares against the real depth so non-power-of-two stacks never
  // step into the unused pointer codes.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == MAX_IDX) ? '0 : p + IW'(1);
  endfunction

  function automatic logic [IW-1:0] wrap_dec(input logic [IW-1:0] p);
    return (p == '0) ? MAX_IDX : p - IW'(1);
  endfunction

  assign ptr_inc    = wrap_inc(ptr);
  assign ptr_dec    = wrap_dec(ptr);
  assign top_target = stack[ptr];
  assign ras_index  = ptr;
  assign ras_count  = count;
  assign empty      = (count == '0);
  assign full       = (count == MAX_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < RAS_ENTRIES; i++) stack[i] <= '0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (restore_valid) begin
        ptr                  <= restore_index;
        count                <= restore_count;
        stack[restore_index] <= restore_target;
      end else if (push_valid && pop_valid) begin
        stack[ptr] <= push_target;
        if (count == '0) count <= CNT_W'(1);
      end else if (push_valid) begin
        ptr            <= ptr_inc;
        stack[ptr_inc] <= push_target;
        if (count < MAX_CNT) count <= count + CNT_W'(1);
        else                 overflow <= 1'b1;
      end else if (pop_valid) begin
        // Pointer still walks back on underflow so stale entries act as a guess.
        ptr <= ptr_dec;
        if (count != '0) count <= count - CNT_W'(1);
        else             underflow <= 1'b1;
      end
    end
  end

  restore_in_range: assert property (@(posedge CLK) disable iff (RST)
    restore_valid |-> (restore_index <= MAX_IDX && restore_count <= MAX_CNT));

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboarded random/directed bench for ras_ckpt at depths 8 and 6 driven in
// lockstep; a stack model built on modulo arithmetic supplies expectations.
module tb_ras_ckpt;

  localparam int TW = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_valid = 1'b0;
  logic [TW-1:0] push_target = '0;
  logic          pop_valid = 1'b0;
  logic          restore_valid = 1'b0;
  logic [2:0]    restore_index = '0;
  logic [3:0]    restore_count = '0;
  logic [TW-1:0] restore_target = '0;

  logic [TW-1:0] top8, top6;
  logic [2:0]    idx8, idx6;
  logic [3:0]    cnt8, cnt6;
  logic          emp8, emp6, ful8, ful6, ovf8, ovf6, unf8, unf6;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ras_ckpt #(.RAS_ENTRIES(8), .RAS_TARGET_WIDTH(TW)) dut8 (
    .CLK(clk), .RST(rst), .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .restore_valid(restore_valid),
    .restore_index(restore_index), .restore_count(restore_count),
    .restore_target(restore_target), .top_target(top8), .ras_index(idx8),
    .ras_count(cnt8), .empty(emp8), .full(ful8), .overflow(ovf8),
    .underflow(unf8));

  ras_ckpt #(.RAS_ENTRIES(6), .RAS_TARGET_WIDTH(TW)) dut6 (
    .CLK(clk), .RST(rst), .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .restore_valid(restore_valid),
    .restore_index(restore_index), .restore_count(restore_count),
    .restore_target(restore_target), .top_target(top6), .ras_index(idx6),
    .ras_count(cnt6), .empty(emp6), .full(ful6), .overflow(ovf6),
    .underflow(unf6));

  typedef struct {
    logic [TW-1:0] top;
    int            idx;
    int            cnt;
    bit            emp, ful, ovf, unf;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];

  int            depth [2] = '{8, 6};
  logic [TW-1:0] mstk [2][8];
  int            mptr [2];
  int            mcnt [2];

  function automatic exp_t model_step(int d, bit r, bit rv, int ri, int rc,
                                      logic [TW-1:0] rt, bit pu,
                                      logic [TW-1:0] pt, bit po);
    exp_t e;
    int   n = depth[d];
    e.ovf = 0;
    e.unf = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) mstk[d][i] = '0;
      mptr[d] = 0;
      mcnt[d] = 0;
    end else if (rv) begin
      mptr[d] = ri;
      mcnt[d] = rc;
      mstk[d][ri] = rt;
    end else if (pu && po) begin
      mstk[d][mptr[d]] = pt;
      if (mcnt[d] == 0) mcnt[d] = 1;
    end else if (pu) begin
      mptr[d] = (mptr[d] + 1) % n;
      mstk[d][mptr[d]] = pt;
      if (mcnt[d] == n) e.ovf = 1;
      else mcnt[d]++;
    end else if (po) begin
      mptr[d] = (mptr[d] + n - 1) % n;
      if (mcnt[d] == 0) e.unf = 1;
      else mcnt[d]--;
    end
    e.top = mstk[d][mptr[d]];
    e.idx = mptr[d];
    e.cnt = mcnt[d];
    e.emp = (mcnt[d] == 0);
    e.ful = (mcnt[d] == n);
    return e;
  endfunction

  task automatic step(input bit r, input bit rv, input int ri, input int rc,
                      input logic [TW-1:0] rt, input bit pu,
                      input logic [TW-1:0] pt, input bit po);
    @(negedge clk);
    rst            = r;
    restore_valid  = rv;
    restore_index  = 3'(ri);
    restore_count  = 4'(rc);
    restore_target = rt;
    push_valid     = pu;
    push_target    = pt;
    pop_valid      = po;
    q8.push_back(model_step(0, r, rv, ri, rc, rt, pu, pt, po));
    q6.push_back(model_step(1, r, rv, ri, rc, rt, pu, pt, po));
    @(posedge clk);
    #2;
    rst = 0; restore_valid = 0; push_valid = 0; pop_valid = 0;
  endtask

  task automatic do_rst();                    step(1, 0, 0, 0, '0, 0, '0, 0); endtask
  task automatic do_push(logic [TW-1:0] t);   step(0, 0, 0, 0, '0, 1, t, 0);  endtask
  task automatic do_pop();                    step(0, 0, 0, 0, '0, 0, '0, 1); endtask
  task automatic do_pp(logic [TW-1:0] t);     step(0, 0, 0, 0, '0, 1, t, 1);  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per instance per clocked request.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      vectors++;
      if (top8 !== e.top || int'(idx8) != e.idx || int'(cnt8) != e.cnt ||
          emp8 !== e.emp || ful8 !== e.ful || ovf8 !== e.ovf || unf8 !== e.unf) begin
        miscompares++;
        $display("FAIL sb8 @%0t: got top=%0h idx=%0d cnt=%0d e=%b f=%b o=%b u=%b, expected top=%0h idx=%0d cnt=%0d e=%b f=%b o=%b u=%b",
                 $time, top8, idx8, cnt8, emp8, ful8, ovf8, unf8,
                 e.top, e.idx, e.cnt, e.emp, e.ful, e.ovf, e.unf);
      end
    end
    if (q6.size() > 0) begin
      e = q6.pop_front();
      vectors++;
      if (top6 !== e.top || int'(idx6) != e.idx || int'(cnt6) != e.cnt ||
          emp6 !== e.emp || ful6 !== e.ful || ovf6 !== e.ovf || unf6 !== e.unf) begin
        miscompares++;
        $display("FAIL sb6 @%0t: got top=%0h idx=%0d cnt=%0d e=%b f=%b o=%b u=%b, expected top=%0h idx=%0d cnt=%0d e=%b f=%b o=%b u=%b",
                 $time, top6, idx6, cnt6, emp6, ful6, ovf6, unf6,
                 e.top, e.idx, e.cnt, e.emp, e.ful, e.ovf, e.unf);
      end
    end
  end

  initial begin
    int ri, rc;
    do_rst();
    chk("reset_top", 64'(top8), 64'h0);
    chk("reset_empty", 64'(emp8), 64'h1);
    chk("reset_full", 64'(ful8), 64'h0);

    do_push(31'h100); do_push(31'h200); do_push(31'h300);
    chk("push3_idx", 64'(idx8), 64'd3);
    chk("push3_cnt", 64'(cnt8), 64'd3);
    chk("push3_top", 64'(top8), 64'h300);
    do_pop();
    chk("pop1_top", 64'(top8), 64'h200);
    do_pop(); do_pop();
    chk("pop3_cnt", 64'(cnt8), 64'd0);
    chk("pop3_idx", 64'(idx8), 64'd0);
    chk("pop3_empty", 64'(emp8), 64'h1);

    do_pop();
    chk("underflow_pulse", 64'(unf8), 64'h1);
    chk("underflow_idx", 64'(idx8), 64'd7);
    chk("underflow_cnt", 64'(cnt8), 64'd0);
    do_pop();
    chk("underflow_stale_top", 64'(top8), 64'h0);

    do_rst();
    for (int i = 1; i <= 8; i++) do_push(TW'(i));
    chk("full_after_8", 64'(ful8), 64'h1);
    chk("no_ovf_at_8", 64'(ovf8), 64'h0);
    do_push(31'h9);
    chk("ovf_pulse", 64'(ovf8), 64'h1);
    chk("ovf_cnt", 64'(cnt8), 64'd8);
    chk("ovf_idx", 64'(idx8), 64'd1);
    chk("ovf_top", 64'(top8), 64'h9);
    do_pop();
    chk("ovf_pulse_clears", 64'(ovf8), 64'h0);
    chk("pop_after_wrap", 64'(top8), 64'h8);
    for (int i = 0; i < 7; i++) do_pop();
    chk("drain_cnt", 64'(cnt8), 64'd0);

    do_rst();
    do_push(31'h11); do_push(31'hAA);
    do_pp(31'hBB);
    chk("pp_top", 64'(top8), 64'hBB);
    chk("pp_idx", 64'(idx8), 64'd2);
    chk("pp_cnt", 64'(cnt8), 64'd2);
    do_rst();
    do_pp(31'hCC);
    chk("pp_empty_cnt", 64'(cnt8), 64'd1);
    chk("pp_empty_top", 64'(top8), 64'hCC);

    do_rst();
    for (int i = 0; i < 5; i++) do_push(TW'(i + 32));
    step(0, 1, 2, 2, 31'h55, 1, 31'h77, 0);
    chk("restore_idx", 64'(idx8), 64'd2);
    chk("restore_cnt", 64'(cnt8), 64'd2);
    chk("restore_top", 64'(top8), 64'h55);

    do_rst();
    for (int i = 1; i <= 7; i++) begin
      do_push(TW'(i + 64));
      chk($sformatf("d6_idx_%0d", i), 64'(idx6), 64'(i % 6));
      chk($sformatf("d6_ovf_%0d", i), 64'(ovf6), 64'(i == 7));
    end
    step(1, 0, 0, 0, '0, 1, 31'h1234, 0);
    chk("rst_over_push_cnt", 64'(cnt6), 64'd0);
    chk("rst_over_push_top", 64'(top6), 64'h0);

    for (int n = 0; n < 2000; n++) begin
      ri = $urandom_range(0, 5);
      rc = $urandom_range(0, 6);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, ri, rc,
           TW'($urandom), $urandom_range(0, 1) == 1, TW'($urandom),
           $urandom_range(0, 2) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(q8.size() + q6.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
